systolic_gemm_tile: RTL and testbench

SYSTOLIC_GEMM_TILE -- requirements
Module: systolic_gemm_tile

---
 rtl/systolic_gemm_tile_pkg.sv | 18 +
 rtl/systolic_gemm_tile_mac_pe.sv | 49 ++++
 rtl/systolic_gemm_tile.sv | 176 +++++++++++++++++
 tb/tb_systolic_gemm_tile.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_gemm_tile_pkg.sv
// Shared types for the GEMM tile and its address generators.
// Holds the tile FSM encoding and the address-generator descriptor.
package params;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } gemm_state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] count;
  } addrgen_t;

endpackage

// File: rtl/systolic_gemm_tile_mac_pe.sv
// One output-stationary MAC cell: a/b forwarded through one register, 1-cycle.
// No backpressure; accumulates only when both operands carry a valid bit.
module gemm_mac_pe #(
  parameter int DW   = 32,
  parameter int ACCW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [DW-1:0]   a,
  input  logic            a_vld,
  input  logic [DW-1:0]   b,
  input  logic            b_vld,
  output logic [DW-1:0]   a_fwd,
  output logic            a_fwd_vld,
  output logic [DW-1:0]   b_fwd,
  output logic            b_fwd_vld,
  output logic [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod;

  // Low 2*DW bits of the sign-extended product equal the exact signed product.
  assign a_ext = {{DW{a[DW-1]}}, a};
  assign b_ext = {{DW{b[DW-1]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_fwd     <= '0;
      a_fwd_vld <= 1'b0;
      b_fwd     <= '0;
      b_fwd_vld <= 1'b0;
      acc       <= '0;
    end else begin
      a_fwd     <= a;
      a_fwd_vld <= a_vld;
      b_fwd     <= b;
      b_fwd_vld <= b_vld;
      if (clr)
        acc <= '0;
      else if (a_vld && b_vld)
        acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/systolic_gemm_tile.sv
// ROWSxCOLS output-stationary GEMM tile; results ROWS+COLS-1 cycles after last beat.
// Operands via in_vld/in_rdy (ready only in FEED); result rows held until out_rdy.
module systolic_gemm_tile
  import params::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 32,
  parameter int ACCW = 64,
  parameter int KW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     accum,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [ROWS*DW-1:0]       a_col,
  input  logic [COLS*DW-1:0]       b_row,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [COLS*ACCW-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0]  out_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int RIW = $clog2(ROWS);
  localparam int DCW = $clog2(ROWS + COLS);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS + COLS - 2);
  localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROWS - 1);

  gemm_state_t     state;
  logic [KW-1:0]   k_len_q;
  logic [KW-1:0]   k_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic [RIW-1:0]  row_idx;
  logic            done_q;
  logic            beat;
  logic            clr;

  logic [DW-1:0]   a_h  [ROWS][COLS+1];
  logic            av_h [ROWS][COLS+1];
  logic [DW-1:0]   b_v  [ROWS+1][COLS];
  logic            bv_v [ROWS+1][COLS];
  logic [ACCW-1:0] acc_w [ROWS][COLS];

  assign in_rdy  = (state == ST_FEED);
  assign beat    = in_vld && in_rdy;
  assign clr     = (state == ST_IDLE) && start && !accum;
  assign busy    = (state != ST_IDLE);
  assign out_vld = (state == ST_OUT);
  assign out_idx = row_idx;
  assign done    = done_q;

  // Row i enters the array i cycles late so it meets column j's data in PE(i,j).
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    if (i == 0) begin : g_d0
      assign a_h[0][0]  = a_col[DW-1:0];
      assign av_h[0][0] = beat;
    end else begin : g_dn
      logic [DW-1:0] dl [i];
      logic [i-1:0]  vl;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) dl[k] <= '0;
          vl <= '0;
        end else begin
          dl[0] <= a_col[i*DW +: DW];
          vl[0] <= beat;
          for (int k = 1; k < i; k++) begin
            dl[k] <= dl[k-1];
            vl[k] <= vl[k-1];
          end
        end
      end
      assign a_h[i][0]  = dl[i-1];
      assign av_h[i][0] = vl[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    if (j == 0) begin : g_d0
      assign b_v[0][0]  = b_row[DW-1:0];
      assign bv_v[0][0] = beat;
    end else begin : g_dn
      logic [DW-1:0] dl [j];
      logic [j-1:0]  vl;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < j; k++) dl[k] <= '0;
          vl <= '0;
        end else begin
          dl[0] <= b_row[j*DW +: DW];
          vl[0] <= beat;
          for (int k = 1; k < j; k++) begin
            dl[k] <= dl[k-1];
            vl[k] <= vl[k-1];
          end
        end
      end
      assign b_v[0][j]  = dl[j-1];
      assign bv_v[0][j] = vl[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      gemm_mac_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .a         (a_h[i][j]),
        .a_vld     (av_h[i][j]),
        .b         (b_v[i][j]),
        .b_vld     (bv_v[i][j]),
        .a_fwd     (a_h[i][j+1]),
        .a_fwd_vld (av_h[i][j+1]),
        .b_fwd     (b_v[i+1][j]),
        .b_fwd_vld (bv_v[i+1][j]),
        .acc       (acc_w[i][j])
      );
    end
  end

  always_comb begin
    out_row = '0;
    if (state == ST_OUT)
      for (int j = 0; j < COLS; j++) out_row[j*ACCW +: ACCW] = acc_w[row_idx][j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      row_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          k_len_q   <= k_len;
          k_cnt     <= '0;
          drain_cnt <= '0;
          state     <= (k_len == '0) ? ST_DRAIN : ST_FEED;
        end
        ST_FEED: if (beat) begin
          k_cnt <= k_cnt + KW'(1);
          if ((k_cnt + KW'(1)) == k_len_q) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Wait for the last beat to ripple through to PE(ROWS-1,COLS-1).
          if (drain_cnt == DRAIN_LAST) begin
            state   <= ST_OUT;
            row_idx <= '0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: if (out_rdy) begin
          if (row_idx == ROW_LAST) begin
            state   <= ST_IDLE;
            row_idx <= '0;
            done_q  <= 1'b1;
          end else begin
            row_idx <= row_idx + RIW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Directed bench for a 4x4 tile: reference matrix model feeds a row scoreboard,
// checked with immediate assertions as rows are handed off.
module tb_systolic_gemm_tile;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int K    = 4;
  localparam int DW   = 32;
  localparam int ACCW = 64;
  localparam int KW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              accum;
  logic              in_vld;
  logic              in_rdy;
  logic [R*DW-1:0]   a_col;
  logic [C*DW-1:0]   b_row;
  logic              out_vld;
  logic              out_rdy;
  logic [C*ACCW-1:0] out_row;
  logic [1:0]        out_idx;
  logic              busy;
  logic              done;

  systolic_gemm_tile #(.ROWS(R), .COLS(C), .DW(DW), .ACCW(ACCW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accum(accum),
    .in_vld(in_vld), .in_rdy(in_rdy), .a_col(a_col), .b_row(b_row),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] am [R][K];
  logic signed [DW-1:0] bm [K][C];
  longint               cm [R][C];
  logic [C*ACCW-1:0]    exp_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ident_b();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K; k++) am[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) bm[k][j] = k * 4 + j;
  endtask

  task automatic set_random();
    int t;
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K; k++) begin t = int'($urandom_range(0, 2000)) - 1000; am[i][k] = t; end
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) begin t = int'($urandom_range(0, 2000)) - 1000; bm[k][j] = t; end
  endtask

  task automatic model(input logic acc_v, input int klen);
    logic [C*ACCW-1:0] row;
    if (!acc_v)
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) cm[i][j] = 0;
    for (int k = 0; k < klen; k++)
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++)
          cm[i][j] = cm[i][j] + longint'(am[i][k]) * longint'(bm[k][j]);
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) row[j*ACCW +: ACCW] = cm[i][j];
      exp_q.push_back(row);
    end
  endtask

  task automatic run_tile(input logic acc_v, input int klen, input bit toggle, input bit stall);
    int beat;
    int cyc;
    int n;
    int g;
    int exp_idx;
    @(negedge clk);
    start = 1'b1; k_len = KW'(klen); accum = acc_v;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    model(acc_v, klen);
    beat = 0; cyc = 0;
    while (beat < klen && cyc < 64) begin
      in_vld = (toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      if (in_vld) begin
        for (int i = 0; i < R; i++) a_col[i*DW +: DW] = am[i][beat];
        for (int j = 0; j < C; j++) b_row[j*DW +: DW] = bm[beat][j];
      end else begin
        a_col = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_row = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (in_vld && in_rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    in_vld = 1'b0;
    chk("beats_fed", beat, klen);
    chk("rdy_low_after_feed", in_rdy, 0);
    n = 0;
    while (!out_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("out_latency", n, 7);
    exp_idx = 0; g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      out_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_vld) begin
        chk("out_row", out_row, exp_q[0]);
        chk("out_idx", out_idx, exp_idx);
        if (out_rdy) begin
          void'(exp_q.pop_front());
          exp_idx++;
        end
      end
      g++;
      @(negedge clk);
    end
    out_rdy = 1'b0;
    chk("rows_left", exp_q.size(), 0);
    exp_q.delete();
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("done_low", done, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_row", out_row, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; accum = 1'b0; k_len = '0;
    in_vld = 1'b0; out_rdy = 1'b0; a_col = '0; b_row = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) cm[i][j] = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;

    set_ident_b();
    run_tile(1'b0, 4, 1'b0, 1'b0);
    run_tile(1'b0, 4, 1'b1, 1'b1);
    run_tile(1'b1, 4, 1'b0, 1'b0);
    run_tile(1'b1, 0, 1'b0, 1'b0);

    set_random();
    run_tile(1'b0, 3, 1'b1, 1'b1);

    for (int i = 0; i < R; i++)
      for (int k = 0; k < K; k++) am[i][k] = 32'sh8000_0000;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) bm[k][j] = 32'sh8000_0000;
    run_tile(1'b0, 4, 1'b0, 1'b0);

    // Partial tile aborted by reset; its accumulation must not leak forward.
    set_random();
    @(negedge clk);
    start = 1'b1; k_len = KW'(4); accum = 1'b0;
    @(negedge clk);
    start = 1'b0; in_vld = 1'b1;
    a_col = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_row = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (2) @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    #1;
    chk_reset_outputs();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) cm[i][j] = 0;
    @(negedge clk);
    rst = 1'b1;
    run_tile(1'b1, 4, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
